// File: rtl/prime_stepper_pkg.sv
// rtl/prime_stepper_pkg.sv - shared FSM encoding and counter width helper for prime_stepper
package prime_stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Bits needed for a counter spanning 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - button synchroniser, optional debounce (PRIME_STEPPER_DEBOUNCE_EN), rising-edge pulse
module step_debounce
    import prime_stepper_pkg::*;
#(
    parameter int DB_CYCLES = 160_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

`ifdef PRIME_STEPPER_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic sync1_q, sync2_q, prev_q, press_q;
    logic lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DB_EN && DB_CYCLES > 0) begin : g_db
            localparam int DW = cnt_width(DB_CYCLES);
            logic [DW-1:0] cnt_q;
            logic          lvl_q;

            // The level only moves after DB_CYCLES consecutive samples disagree with it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else if (sync2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DW'(DB_CYCLES - 1)) begin
                    cnt_q <= '0;
                    lvl_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign lvl = lvl_q;
        end else begin : g_nodb
            assign lvl = sync2_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= lvl;
            press_q <= lvl & ~prev_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/prime_stepper.sv
// rtl/prime_stepper.sv - prime generator request sequencer with LED slice display; button debounce via PRIME_STEPPER_DEBOUNCE_EN
module prime_stepper
    import prime_stepper_pkg::*;
#(
    parameter int RES_W      = 16,
    parameter int LED_N      = 4,
    parameter int PERIOD     = 80_000_000,
    parameter int ROT_CYCLES = 16_000_000,
    parameter int CNT_W      = 16,
    parameter int DB_CYCLES  = 160_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_en,
    input  logic             rotate_en,
    input  logic             step_btn,
    output logic             gen_go,
    input  logic             gen_ready,
    input  logic             gen_error,
    input  logic [RES_W-1:0] gen_res,
    output logic [LED_N-1:0] led,
    output logic             err_led,
    output logic             overrun,
    output logic [CNT_W-1:0] prime_cnt
);

    localparam int NSLICE = RES_W / LED_N;
    localparam int TW     = cnt_width(PERIOD);
    localparam int RW     = cnt_width(ROT_CYCLES);
    localparam int IW     = cnt_width(NSLICE);

    state_e           state_q, state_d;
    logic             ovr_q, ovr_d;
    logic             err_q, err_d;
    logic             latch;
    logic [TW-1:0]    timer_q;
    logic [RW-1:0]    rot_q;
    logic [IW-1:0]    idx_q;
    logic [RES_W-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick, press, trig;

    step_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .press (press)
    );

    assign tick = auto_en & (timer_q == TW'(PERIOD - 1));
    assign trig = auto_en ? tick : press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer_q <= '0;
        else if (!auto_en || tick)
            timer_q <= '0;
        else
            timer_q <= timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        err_d   = err_q;
        latch   = 1'b0;
        gen_go  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig && gen_ready && !gen_error) begin
                    state_d = ST_ISSUE;
                end else begin
                    if (trig)
                        ovr_d = 1'b1;
                    if (gen_ready && gen_error)
                        state_d = ST_HALT;
                end
            end
            ST_ISSUE: begin
                gen_go  = 1'b1;
                state_d = ST_GUARD;
                if (trig)
                    ovr_d = 1'b1;
            end
            // The generator may still show ready from the previous result here.
            ST_GUARD: begin
                state_d = ST_WAIT;
                if (trig)
                    ovr_d = 1'b1;
            end
            ST_WAIT: begin
                if (trig)
                    ovr_d = 1'b1;
                if (gen_ready) begin
                    if (gen_error) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        latch   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            cnt_q <= '0;
        end else if (latch) begin
            res_q <= gen_res;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // A fresh result restarts the display from slice 0 with a full rotation interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= '0;
            idx_q <= '0;
        end else if (latch || !rotate_en) begin
            rot_q <= '0;
            idx_q <= '0;
        end else if (rot_q == RW'(ROT_CYCLES - 1)) begin
            rot_q <= '0;
            idx_q <= (idx_q == IW'(NSLICE - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            rot_q <= rot_q + 1'b1;
        end
    end

    assign led       = res_q[LED_N*idx_q +: LED_N];
    assign err_led   = err_q;
    assign overrun   = ovr_q;
    assign prime_cnt = cnt_q;

endmodule

// File: doc/prime_stepper.md
# prime_stepper

Parametrised sequencer between a prime generator (go/ready/error/res handshake) and a small LED bank. Issues one generator request per trigger: periodic timer tick in auto mode, or a synchronised push-button edge in manual mode. Latches each result, shows a selectable or rotating bit-slice of it on LEDs and flags generator errors and dropped triggers. Sits at board top level between the clock/POR logic and the generator instance.

## Interface
- `RES_W`, 16: generator result width; power of two, ≥ `LED_N`.
- `LED_N`, 4: number of result LEDs; must divide `RES_W`.
- `PERIOD`, 80_000_000: auto-mode tick period in `clk` cycles, ≥ 2.
- `ROT_CYCLES`, 16_000_000: slice rotation period in cycles, ≥ 2.
- `CNT_W`, 16: width of the prime counter.
- `DB_CYCLES`, 160_000: debounce stability window; used only with the debounce macro.
- `clk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `auto_en` in 1: 1 = timer triggers, 0 = button triggers.
- `rotate_en` in 1: 1 = rotate the displayed slice; 0 = show slice 0.
- `step_btn` in 1: raw asynchronous push-button.
- `gen_go` out 1: one-cycle request to the generator.
- `gen_ready` in 1: generator idle and result valid.
- `gen_error` in 1: generator error; valid while `gen_ready`=1.
- `gen_res` in `RES_W`: generator result.
- `led` out `LED_N`: displayed slice of the latched result.
- `err_led` out 1: sticky generator error.
- `overrun` out 1: sticky; a trigger was dropped.
- `prime_cnt` out `CNT_W`: results latched since reset; saturates at all-ones.

## Operation
- Reset values: `gen_go`=0, `led`=0, `err_led`=0, `overrun`=0, `prime_cnt`=0. Result register, timer, slice index and rotation counter are all 0. FSM is in IDLE.
- Timer:
  - Counts 0..`PERIOD`-1 while `auto_en`=1 and wraps. `tick` pulses on the `PERIOD`-1 → 0 wrap.
  - Held at 0 while `auto_en`=0.
- Button path: 2-FF synchroniser, then rising-edge detect. Produces a one-cycle `press`. `press` is ignored while `auto_en`=1.
- `trig` = (`auto_en` & `tick`) | (!`auto_en` & `press`).
- FSM states: IDLE, ISSUE, GUARD, WAIT, HALT.
  - IDLE: `trig` & `gen_ready` & !`gen_error` → ISSUE. `trig` otherwise sets `overrun`. `gen_ready` & `gen_error` → HALT.
  - ISSUE: `gen_go`=1 for exactly this cycle → GUARD.
  - GUARD: one cycle in which `gen_ready` is ignored, giving the generator a cycle to register `go` → WAIT.
  - WAIT: on `gen_ready`=1:
    - if `gen_error`=1: set `err_led` → HALT.
    - else: latch `gen_res`, increment `prime_cnt` (saturating) → IDLE.
  - Any `trig` in ISSUE, GUARD or WAIT sets `overrun`; no request is queued.
  - HALT: terminal until `rst`. Triggers are ignored and do not set `overrun`. `led` keeps the last good result.
- Display:
  - `led` = result[`LED_N`*idx +: `LED_N`], where idx ∈ 0..`RES_W`/`LED_N`-1.
  - With `rotate_en`=1, idx advances every `ROT_CYCLES` and wraps to 0.
  - With `rotate_en`=0, idx and the rotation counter are held at 0.
  - idx resets to 0 whenever a new result is latched.

## Timing
- `trig` at cycle t → `gen_go` high at t+1, for one cycle only.
- `gen_ready` sampled from t+3 onward.
- `gen_ready` sampled high at cycle r → result, `led` and `prime_cnt` update at r+1; FSM back in IDLE at r+1.
- Back-to-back: a `trig` in the same cycle the FSM returns to IDLE is accepted.
- Button: edge on `step_btn` → `press` 3 cycles later (sync + edge register).
- Asynchronous `rst` mid-WAIT: immediately IDLE, `gen_go`=0, all flags cleared.

## Configuration
- `PRIME_STEPPER_DEBOUNCE_EN` defined: after synchronisation, `step_btn` must hold a constant level for `DB_CYCLES` consecutive cycles before the debounced level changes. `press` is generated on the debounced rising edge, adding `DB_CYCLES` of latency.
- Undefined: synchroniser + edge detect only; `DB_CYCLES` unused.

## Structure
- Package `prime_stepper_pkg`:
  - FSM state encoding (IDLE=0, ISSUE=1, GUARD=2, WAIT=3, HALT=4).
  - Width helpers for the timer, rotation and slice counters.
- Sub-module `step_debounce`: synchroniser, optional debounce, rising-edge pulse. Ports `clk`, `rst`, `btn`, `press`.

## Test plan
- `RES_W`=16, `LED_N`=4, `PERIOD`=10, `auto_en`=1, generator model returns 0x0007 with 5-cycle busy:
  - `gen_go` pulses at cycles 10, 20, 30.
  - `prime_cnt` = 1, 2, 3.
  - `led`=4'h7.
- Manual mode, generator busy 30 cycles, two presses 8 cycles apart → one `gen_go`; `overrun`=1; `prime_cnt`=1.
- `rotate_en`=1, `ROT_CYCLES`=4, result 0xABCD → `led` sequence D, C, B, A, D at 4-cycle spacing.
- Generator returns `gen_error`=1 on the second request:
  - `err_led`=1; FSM in HALT.
  - `led` still shows the first result.
  - Further ticks produce no `gen_go` and leave `overrun`=0.
- `rst` asserted 2 cycles into WAIT → all outputs 0 in the same cycle; normal operation on the next tick.
- With `PRIME_STEPPER_DEBOUNCE_EN`, `DB_CYCLES`=5, button bouncing 1-cycle pulses for 4 cycles then steady high → exactly one `gen_go`.
